// File: rtl/weight_update_seq_pkg.sv
// rtl/weight_update_seq_pkg.sv - shared filter package: Q-format defaults and sequencer states
package weight_update_seq_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_QP    = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/weight_update_seq_term_add.sv
// rtl/weight_update_seq_term_add.sv - weight_term_add: rounded Q-format product added to a weight
module weight_term_add
   import weight_update_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int QP    = DEF_QP
) (
   input  logic [WIDTH-1:0] mu_error,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] weight,
   output logic [WIDTH-1:0] new_weight
);

   // Half an LSB of the result, added before dropping the fraction bits.
   localparam logic [2*WIDTH-1:0] HALF = {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP-1);

   logic signed [2*WIDTH-1:0] x_ext;
   logic signed [2*WIDTH-1:0] mu_ext;
   logic signed [2*WIDTH-1:0] full;
   logic        [2*WIDTH-1:0] rnd;
   logic        [WIDTH-1:0]   term;

   // Full-precision signed product, round half up, keep the integer window; add wraps.
   always_comb begin
      x_ext      = {{WIDTH{x[WIDTH-1]}}, x};
      mu_ext     = {{WIDTH{mu_error[WIDTH-1]}}, mu_error};
      full       = x_ext * mu_ext;
      rnd        = full + HALF;
      term       = WIDTH'(rnd >> QP);
      new_weight = weight + term;
   end

endmodule

// File: rtl/weight_update_seq.sv
// rtl/weight_update_seq.sv - sequential LMS weight updater, one tap per cycle
module weight_update_seq
   import weight_update_seq_pkg::*;
#(
   parameter int              WIDTH     = DEF_WIDTH,
   parameter int              QP        = DEF_QP,
   parameter int              N_TAPS    = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [WIDTH-1:0]          x_n,
   input  logic [WIDTH-1:0]          mu_error,
   input  logic [$clog2(N_TAPS)-1:0] rd_idx,
   output logic [WIDTH-1:0]          rd_weight,
   output logic                      busy,
   output logic                      done
);

   localparam int IW = $clog2(N_TAPS);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] weight [N_TAPS];
   logic [WIDTH-1:0] x_d    [N_TAPS];
   logic [WIDTH-1:0] mu_l;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] w_next;

   // Single shared term/adder, steered to the current tap by idx.
   weight_term_add #(
      .WIDTH (WIDTH),
      .QP    (QP)
   ) u_term_add (
      .mu_error   (mu_l),
      .x          (x_d[idx]),
      .weight     (weight[idx]),
      .new_weight (w_next)
   );

   // State register; reset always lands in IDLE, dropping any start in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and status flags; busy and done decode distinct states so never overlap.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            busy = 1'b1;
            if (idx == IW'(N_TAPS-1)) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Datapath: sample capture, per-tap write, and read port sampled before this edge's write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            weight[k] <= RESET_VAL;
            x_d[k]    <= '0;
         end
         mu_l      <= '0;
         idx       <= '0;
         rd_weight <= '0;
      end else begin
         rd_weight <= weight[rd_idx];
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x_d[0] <= x_n;
                  for (int k = 1; k < N_TAPS; k++) begin
                     x_d[k] <= x_d[k-1];
                  end
                  mu_l <= mu_error;
                  idx  <= '0;
               end
            end
            ST_UPDATE: begin
               weight[idx] <= w_next;
               idx         <= idx + IW'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_update_seq.sv
// tb/tb_weight_update_seq.sv - scoreboard bench for weight_update_seq
module tb_weight_update_seq;

   localparam int W  = 16;
   localparam int NT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  x_n;
   logic [W-1:0]  mu_error;
   logic [2:0]    rd_idx;
   logic [W-1:0]  rd_weight;
   logic          busy;
   logic          done;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;
   logic          mon_en = 1'b0;
   logic          rd_req = 1'b0;
   logic          rd_v   = 1'b0;

   logic [W-1:0]  rq_val  [$];
   string         rq_name [$];
   int            dq      [$];

   weight_update_seq #(
      .WIDTH     (W),
      .QP        (12),
      .N_TAPS    (NT),
      .RESET_VAL ('0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x_n       (x_n),
      .mu_error  (mu_error),
      .rd_idx    (rd_idx),
      .rd_weight (rd_weight),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_v <= rd_req;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: read responses, done pulses and busy/done exclusivity.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_v) begin
            if (rq_val.size() == 0) begin
               chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
               chk(rq_name.pop_front(), 32'(rd_weight), 32'(rq_val.pop_front()));
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               chk("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
            end
         end
         chk("busy_and_done", 32'(busy & done), 32'd0);
      end
   end

   task automatic issue_read(input int k, input logic [W-1:0] exp);
      rd_idx = 3'(k);
      rd_req = 1'b1;
      rq_val.push_back(exp);
      rq_name.push_back($sformatf("rd_w%0d", k));
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] mu, input bit accept);
      x_n      = x;
      mu_error = mu;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      if (accept) dq.push_back(cyc + NT);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n >= 40), 32'd0);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      x_n      = '0;
      mu_error = '0;
      rd_idx   = '0;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rd_weight", 32'(rd_weight), 32'd0);
      for (int k = 0; k < NT; k++) issue_read(k, 16'h0000);

      // Basic update: only tap 0 sees a nonzero sample.
      do_start(16'h1000, 16'h0800, 1'b1);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_idle();
      issue_read(0, 16'h0800);
      issue_read(1, 16'h0000);
      issue_read(7, 16'h0000);

      // Rounding: half rounds up.
      do_start(16'h0001, 16'h0800, 1'b1);
      wait_idle();
      issue_read(0, 16'h0801);
      issue_read(1, 16'h0800);

      // Rounding: just under half rounds down.
      do_start(16'h0001, 16'h07FF, 1'b1);
      wait_idle();
      issue_read(0, 16'h0801);
      issue_read(1, 16'h0800);
      issue_read(2, 16'h07FF);

      // Negative mu: tiny taps add 0, tap 3 goes negative; read-before-write on tap 3.
      do_start(16'h0001, 16'hF800, 1'b1);
      repeat (3) @(negedge clk);
      issue_read(3, 16'h0000);
      issue_read(3, 16'hF800);
      wait_idle();
      issue_read(0, 16'h0801);
      issue_read(1, 16'h0800);
      issue_read(2, 16'h07FF);
      issue_read(4, 16'h0000);

      // Reset on write 4 of 8, with a start in the reset cycle.
      do_start(16'h1234, 16'h1000, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      chk("busy_after_abort", 32'(busy), 32'd0);
      @(negedge clk);
      chk("busy_after_reset_start", 32'(busy), 32'd0);
      for (int k = 0; k < NT; k++) issue_read(k, 16'h0000);

      // Negative sample on a zero weight.
      do_start(16'hF000, 16'h0800, 1'b1);
      wait_idle();
      issue_read(0, 16'hF800);
      issue_read(1, 16'h0000);

      // Wrap: 0x7F00 + 0x0800 -> 0x8700.
      pulse_reset();
      do_start(16'h7F00, 16'h1000, 1'b1);
      wait_idle();
      issue_read(0, 16'h7F00);
      do_start(16'h0800, 16'h1000, 1'b1);
      wait_idle();
      issue_read(0, 16'h8700);
      issue_read(1, 16'h7F00);

      // Back-to-back starts: busy and DONE-cycle starts are dropped.
      pulse_reset();
      do_start(16'h1000, 16'h1000, 1'b1);
      repeat (3) @(negedge clk);
      x_n = 16'h2000; mu_error = 16'h2000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("in_done_cycle", 32'(done), 32'd1);
      x_n = 16'h3000; mu_error = 16'h3000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done_start", 32'(busy), 32'd0);
      do_start(16'h0000, 16'h1000, 1'b1);
      wait_idle();
      issue_read(0, 16'h1000);
      issue_read(1, 16'h1000);
      issue_read(2, 16'h0000);

      repeat (3) @(negedge clk);
      chk("rd_queue_empty", 32'(rq_val.size()), 32'd0);
      chk("done_queue_empty", 32'(dq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
